// File: rtl/alu_op_sequencer.sv
// Issues one request at a time to the shared ALU datapath and returns its result (optional rsp_flags: ALU_SEQ_FLAGS_EN).
// Latency: rsp_valid rises MULT_LAT / DIV_LAT / 1 edges after the accepting edge (div-by-zero and illegal ops: 1).
// Backpressure: req_ready only in IDLE; a response is held in RESP until rsp_ready, stalling all new requests.
module alu_op_sequencer #(
  parameter int N        = 4,
  parameter int MULT_LAT = 2,
  parameter int DIV_LAT  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic [3:0]   alu_control,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
`ifdef ALU_SEQ_FLAGS_EN
  output logic [1:0]   rsp_flags,
`endif
  output logic         rsp_err
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_LAST = 4'd9;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_m1;
  logic          op_illegal;
  logic          div_zero;
  logic          accept;
  logic          done;
  logic          err_q;
  logic          div_zero_q;
  logic [N-1:0]  result_nxt;

  assign op_illegal = (req_op > OP_LAST);
  assign div_zero   = (req_op == OP_DIV) && (req_b == '0);
  assign accept     = (state == IDLE) && req_valid;
  assign done       = (state == EXEC) && (cnt == '0);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  // A zero divisor never reaches the datapath result; the response is forced.
  assign result_nxt = div_zero_q ? '1 : alu_result;

  always_comb begin
    lat_m1 = '0;
    if (req_op == OP_MULT)
      lat_m1 = CW'(MULT_LAT - 1);
    else if ((req_op == OP_DIV) && !div_zero)
      lat_m1 = CW'(DIV_LAT - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)     state_nxt = EXEC;
      EXEC:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      div_zero_q  <= 1'b0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        alu_control <= op_illegal ? 4'b0000 : req_op;
        alu_a       <= req_a;
        alu_b       <= req_b;
        cnt         <= lat_m1;
        err_q       <= op_illegal || div_zero;
        div_zero_q  <= div_zero;
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        rsp_result <= result_nxt;
        rsp_err    <= err_q;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rsp_flags <= 2'b00;
    else if (done)
      rsp_flags <= {result_nxt[N-1], (result_nxt == '0)};
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU datapath on the alu_* ports.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [3:0] alu_control;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0] rsp_flags;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_op_sequencer #(.N(4), .MULT_LAT(2), .DIV_LAT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_flags   (rsp_flags),
`endif
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: ARMv4-style result mux.
  always_comb begin
    alu_result = 4'h0;
    case (alu_control)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a * alu_b;
      4'd3: alu_result = (alu_b == 4'h0) ? 4'h0 : alu_a / alu_b;
      4'd4: alu_result = alu_a << alu_b;
      4'd5: alu_result = alu_a >> alu_b;
      4'd6: alu_result = alu_a & alu_b;
      4'd7: alu_result = alu_a | alu_b;
      4'd8: alu_result = alu_a ^ alu_b;
      4'd9: alu_result = ~alu_a;
      default: alu_result = 4'h0;
    endcase
  end

  // Issue one request from IDLE; report edges until rsp_valid, the ALU code seen, and
  // how many EXEC cycles the ALU inputs moved away from their first EXEC values.
  task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int edges, output logic [3:0] ctl, output int drift);
    logic [3:0] ca, cb;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ctl = alu_control; ca = alu_a; cb = alu_b;
    drift = 0; edges = 0;
    while (!rsp_valid && edges < 50) begin
      if (alu_control !== ctl || alu_a !== ca || alu_b !== cb) drift++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_result !== 4'h0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_result, rsp_err); end
    vectors++; if (alu_control !== 4'h0 || alu_a !== 4'h0 || alu_b !== 4'h0) begin miscompares++; $display("FAIL reset_alu got %h %h %h want 0 0 0", alu_control, alu_a, alu_b); end
`ifdef ALU_SEQ_FLAGS_EN
    vectors++; if (rsp_flags !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", rsp_flags); end
`endif
  endtask

  task automatic test_add();
    int e, d; logic [3:0] c;
    run_op(4'd0, 4'd3, 4'd5, e, c, d);
    vectors++; if (e !== 1) begin miscompares++; $display("FAIL add_latency got %0d want 1", e); end
    vectors++; if (c !== 4'b0000) begin miscompares++; $display("FAIL add_ctl got %b want 0000", c); end
    vectors++; if (rsp_result !== 4'd8 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL add_rsp got %h/%b want 8/0", rsp_result, rsp_err); end
    vectors++; if (alu_a !== 4'd3 || alu_b !== 4'd5) begin miscompares++; $display("FAIL add_operands got %h %h want 3 5", alu_a, alu_b); end
    take_rsp();
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_release got rdy=%b vld=%b want 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_mult();
    int e, d; logic [3:0] c;
    run_op(4'd2, 4'd3, 4'd3, e, c, d);
    vectors++; if (e !== 2) begin miscompares++; $display("FAIL mult_latency got %0d want 2", e); end
    vectors++; if (c !== 4'b0010 || d !== 0) begin miscompares++; $display("FAIL mult_ctl got %b drift=%0d want 0010 drift=0", c, d); end
    vectors++; if (rsp_result !== 4'd9 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL mult_rsp got %h/%b want 9/0", rsp_result, rsp_err); end
`ifdef ALU_SEQ_FLAGS_EN
    vectors++; if (rsp_flags !== 2'b10) begin miscompares++; $display("FAIL mult_flags got %b want 10", rsp_flags); end
`endif
    take_rsp();
    vectors++; if (alu_control !== 4'b0010 || alu_a !== 4'd3) begin miscompares++; $display("FAIL mult_idle_hold got %b %h want 0010 3", alu_control, alu_a); end
  endtask

  task automatic test_div();
    int e, d; logic [3:0] c;
    run_op(4'd3, 4'd7, 4'd0, e, c, d);
    vectors++; if (e !== 1) begin miscompares++; $display("FAIL divz_latency got %0d want 1", e); end
    vectors++; if (rsp_result !== 4'hF || rsp_err !== 1'b1) begin miscompares++; $display("FAIL divz_rsp got %h/%b want f/1", rsp_result, rsp_err); end
    take_rsp();
    run_op(4'd3, 4'd8, 4'd2, e, c, d);
    vectors++; if (e !== 4) begin miscompares++; $display("FAIL div_latency got %0d want 4", e); end
    vectors++; if (c !== 4'b0011 || d !== 0) begin miscompares++; $display("FAIL div_ctl got %b drift=%0d want 0011 drift=0", c, d); end
    vectors++; if (rsp_result !== 4'd4 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL div_rsp got %h/%b want 4/0", rsp_result, rsp_err); end
    take_rsp();
  endtask

  task automatic test_illegal();
    int e, d; logic [3:0] c;
    run_op(4'b1111, 4'd1, 4'd2, e, c, d);
    vectors++; if (e !== 1) begin miscompares++; $display("FAIL illegal_latency got %0d want 1", e); end
    vectors++; if (c !== 4'b0000) begin miscompares++; $display("FAIL illegal_ctl got %b want 0000", c); end
    vectors++; if (rsp_err !== 1'b1 || rsp_result !== 4'd3) begin miscompares++; $display("FAIL illegal_rsp got %h/%b want 3/1", rsp_result, rsp_err); end
    take_rsp();
  endtask

  task automatic test_single_cycle_ops();
    logic [3:0] ops [7] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    logic [3:0] as  [7] = '{4'd3, 4'd12, 4'd12, 4'd12, 4'd12, 4'd5, 4'd2};
    logic [3:0] bs  [7] = '{4'd1, 4'd2, 4'd10, 4'd3, 4'd10, 4'd0, 4'd2};
    logic [3:0] exp [7] = '{4'd6, 4'd3, 4'd8, 4'd15, 4'd6, 4'd10, 4'd0};
    for (int i = 0; i < 7; i++) begin
      int e, d; logic [3:0] c;
      run_op(ops[i], as[i], bs[i], e, c, d);
      vectors++;
      if (e !== 1 || c !== ops[i] || rsp_result !== exp[i] || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL op%0d got lat=%0d ctl=%h res=%h err=%b want 1 %h %h 0", ops[i], e, c, rsp_result, rsp_err, ops[i], exp[i]);
      end
`ifdef ALU_SEQ_FLAGS_EN
      if (ops[i] == 4'd1) begin
        vectors++; if (rsp_flags !== 2'b01) begin miscompares++; $display("FAIL sub_flags got %b want 01", rsp_flags); end
      end
`endif
      take_rsp();
    end
  endtask

  task automatic test_stall();
    int e, d, bad; logic [3:0] c;
    run_op(4'd2, 4'd3, 4'd3, e, c, d);
    // A competing request during the stall must be ignored.
    req_op = 4'd0; req_a = 4'd1; req_b = 4'd1; req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_result !== 4'd9 || req_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got rdy=%b vld=%b want 1 0", req_ready, rsp_valid); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_no_accept got rdy=%b want 1", req_ready); end
  endtask

  task automatic test_reset_mid();
    int seen;
    req_op = 4'd3; req_a = 4'd8; req_b = 4'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_async got vld=%b rdy=%b want 0 1", rsp_valid, req_ready); end
    vectors++; if (alu_control !== 4'h0 || alu_a !== 4'h0 || rsp_result !== 4'h0) begin miscompares++; $display("FAIL midreset_values got %h %h %h want 0 0 0", alu_control, alu_a, rsp_result); end
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_rsp got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 4'h0; req_b = 4'h0; rsp_ready = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_add();
    test_mult();
    test_div();
    test_illegal();
    test_single_cycle_ops();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
